// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM encoding and default operand width.
package serial_adder_pkg;

    localparam int unsigned DEFAULT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the only arithmetic element of the serial adder datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial W-bit adder: operands are shifted LSB-first through one shared full_adder.
// Optional signed-overflow output is enabled with SERIAL_ADD_OVF_EN.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(W + 1);

    state_e             state_q, state_d;
    logic [W-1:0]       a_sh_q, a_sh_d;
    logic [W-1:0]       b_sh_q, b_sh_d;
    logic [W-1:0]       sum_sh_q, sum_sh_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef SERIAL_ADD_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic fa_sum;
    logic fa_carry;

    full_adder u_full_adder (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .c     (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Next-state and datapath control; IDLE and DONE accept a start identically.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = (sum_sh_q >> 1) | (W'(fa_sum) << (W - 1));
                carry_d  = fa_carry;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(W - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    sum_d   = sum_sh_d;
                    cout_d  = fa_carry;
`ifdef SERIAL_ADD_OVF_EN
                    // Carry into the MSB is the carry register on the final bit.
                    ovf_d   = carry_q ^ fa_carry;
`endif
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (W=8); overflow cases run with SERIAL_ADD_OVF_EN.
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf;
`endif

    int n_checks;
    int n_fail;

    serial_adder_ctrl #(.W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one cycle; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one add and observe it until the expected done cycle (t+9).
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_op, input logic tc,
                          output int busy_cyc, output int done_early,
                          output logic done_end, output logic busy_end,
                          output logic [7:0] s, output logic c);
        a = ta; b = tb_op; cin = tc; start = 1'b1;
        step();
        start = 1'b0; a = ~ta; b = 8'h5A; cin = ~tc;
        busy_cyc = 0; done_early = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy === 1'b1) busy_cyc++;
            if (done === 1'b1) done_early++;
            step();
        end
        done_end = done; busy_end = busy; s = sum; c = cout;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        step(); step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum: got %h want 00", sum); end
        n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b want 0", cout); end
`ifdef SERIAL_ADD_OVF_EN
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int bc, de;
        logic de_end, be_end, c;
        logic [7:0] s;
        run_op(8'h3C, 8'h05, 1'b0, bc, de, de_end, be_end, s, c);
        n_checks++; if (bc != 8) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 8", bc); end
        n_checks++; if (de != 0) begin n_fail++; $display("FAIL basic_early_done: got %0d want 0", de); end
        n_checks++; if (de_end !== 1'b1) begin n_fail++; $display("FAIL basic_done_t9: got %b want 1", de_end); end
        n_checks++; if (be_end !== 1'b0) begin n_fail++; $display("FAIL basic_busy_t9: got %b want 0", be_end); end
        n_checks++; if (s !== 8'h41) begin n_fail++; $display("FAIL basic_sum: got %h want 41", s); end
        n_checks++; if (c !== 1'b0) begin n_fail++; $display("FAIL basic_cout: got %b want 0", c); end
        step();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", done); end
        n_checks++; if (sum !== 8'h41) begin n_fail++; $display("FAIL basic_sum_held: got %h want 41", sum); end

        run_op(8'hFF, 8'h01, 1'b0, bc, de, de_end, be_end, s, c);
        n_checks++; if (de_end !== 1'b1) begin n_fail++; $display("FAIL carry_done: got %b want 1", de_end); end
        n_checks++; if (s !== 8'h00) begin n_fail++; $display("FAIL carry_sum: got %h want 00", s); end
        n_checks++; if (c !== 1'b1) begin n_fail++; $display("FAIL carry_cout: got %b want 1", c); end
        step();

        run_op(8'h00, 8'h00, 1'b1, bc, de, de_end, be_end, s, c);
        n_checks++; if (s !== 8'h01) begin n_fail++; $display("FAIL cin_sum: got %h want 01", s); end
        n_checks++; if (c !== 1'b0) begin n_fail++; $display("FAIL cin_cout: got %b want 0", c); end
        step();
    endtask

    task automatic test_start_in_shift();
        int n_done;
        logic [7:0] s_seen;
        logic c_seen;
        n_done = 0; s_seen = 8'h00; c_seen = 1'b0;
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ignore_busy: got %b want 1", busy); end
        for (int i = 0; i < 14; i++) begin
            if (done === 1'b1) begin n_done++; s_seen = sum; c_seen = cout; end
            step();
        end
        n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", n_done); end
        n_checks++; if (s_seen !== 8'h46) begin n_fail++; $display("FAIL ignore_sum: got %h want 46", s_seen); end
        n_checks++; if (c_seen !== 1'b0) begin n_fail++; $display("FAIL ignore_cout: got %b want 0", c_seen); end
    endtask

    task automatic test_reset_mid_shift();
        int n_done, n_busy;
        n_done = 0; n_busy = 0;
        a = 8'hAA; b = 8'h66; cin = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b want 0", done); end
        n_checks++; if (sum !== 8'h00) begin n_fail++; $display("FAIL rstmid_sum: got %h want 00", sum); end
        n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL rstmid_cout: got %b want 0", cout); end
        for (int i = 0; i < 12; i++) begin
            step();
            if (done === 1'b1) n_done++;
            if (busy === 1'b1) n_busy++;
        end
        n_checks++; if (n_done != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d want 0", n_done); end
        n_checks++; if (n_busy != 0) begin n_fail++; $display("FAIL rstmid_idle: got %0d busy cycles want 0", n_busy); end
    endtask

    task automatic test_back_to_back();
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        step();
        a = 8'h10; b = 8'h20;
        for (int i = 0; i < 8; i++) step();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got %b want 1", done); end
        n_checks++; if (sum !== 8'h03) begin n_fail++; $display("FAIL b2b_first_sum: got %h want 03", sum); end
        step();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_no_idle: got busy %b want 1", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_low: got %b want 0", done); end
        for (int i = 0; i < 8; i++) step();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done: got %b want 1", done); end
        n_checks++; if (sum !== 8'h30) begin n_fail++; $display("FAIL b2b_second_sum: got %h want 30", sum); end
        n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL b2b_second_cout: got %b want 0", cout); end
        step();
    endtask

`ifdef SERIAL_ADD_OVF_EN
    task automatic test_ovf();
        int bc, de;
        logic de_end, be_end, c;
        logic [7:0] s;
        run_op(8'h7F, 8'h01, 1'b0, bc, de, de_end, be_end, s, c);
        n_checks++; if (s !== 8'h80) begin n_fail++; $display("FAIL ovf_pos_sum: got %h want 80", s); end
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_pos_flag: got %b want 1", ovf); end
        step();
        run_op(8'hFF, 8'h01, 1'b0, bc, de, de_end, be_end, s, c);
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_neg_flag: got %b want 0", ovf); end
        n_checks++; if (c !== 1'b1) begin n_fail++; $display("FAIL ovf_neg_cout: got %b want 1", c); end
        step();
    endtask
`endif

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        test_reset();
        test_basic();
        test_start_in_shift();
        test_reset_mid_shift();
        test_back_to_back();
`ifdef SERIAL_ADD_OVF_EN
        test_ovf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
